// File: rtl/pwl_rom_loader_pkg.sv
// Shared PWL table constants, entry format and loader state encoding.
package pwl_rom_loader_pkg;

  localparam int unsigned PWL_ADDR_WIDTH   = 8;
  localparam int unsigned PWL_OFFSET_WIDTH = 18;
  localparam int unsigned PWL_SLOPE_WIDTH  = 18;

  typedef struct packed {
    logic [PWL_OFFSET_WIDTH-1:0] offset;
    logic [PWL_SLOPE_WIDTH-1:0]  slope;
  } PWL_ENTRY_FORMAT;

  typedef enum logic [2:0] {
    StIdle,
    StOffs,
    StSlope,
    StFlush,
    StDone
  } pwl_loader_state_t;

endpackage

// File: rtl/pwl_rom_loader.sv
// Packs an offset/slope word stream into {offset, slope} entries and writes them
// to sequential RAM addresses from 0, flagging done once the table is complete.
module pwl_rom_loader
  import pwl_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = PWL_ADDR_WIDTH,
  parameter int unsigned OFFSET_WIDTH = PWL_OFFSET_WIDTH,
  parameter int unsigned SLOPE_WIDTH  = PWL_SLOPE_WIDTH,
  parameter int unsigned IN_WIDTH     = 18
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ADDR_WIDTH:0]                 num_entries,
  input  logic [IN_WIDTH-1:0]                 in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                wr_en,
  output logic [ADDR_WIDTH-1:0]               wr_addr,
  output logic [OFFSET_WIDTH+SLOPE_WIDTH-1:0] wr_data,
  output logic                                busy,
  output logic                                done
);

  localparam logic [ADDR_WIDTH:0] MaxEntries = {1'b1, {ADDR_WIDTH{1'b0}}};

  pwl_loader_state_t                    state_q, state_d;
  logic [ADDR_WIDTH:0]                  total_q, total_d;
  logic [ADDR_WIDTH:0]                  count_q, count_d;
  logic [OFFSET_WIDTH-1:0]              offset_q, offset_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]                wr_addr_q, wr_addr_d;
  logic [OFFSET_WIDTH+SLOPE_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  logic                beat;
  logic [ADDR_WIDTH:0] count_inc;

  assign beat      = in_valid & in_ready_q;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    count_d    = count_q;
    offset_d   = offset_q;
    in_ready_d = in_ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (num_entries == '0) begin
            state_d    = StDone;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
          end else begin
            // Oversized requests are clamped so wr_addr can never wrap.
            total_d    = (num_entries > MaxEntries) ? MaxEntries : num_entries;
            count_d    = '0;
            done_d     = 1'b0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            state_d    = StOffs;
          end
        end
      end
      StOffs: begin
        if (beat) begin
          offset_d = in_data[OFFSET_WIDTH-1:0];
          state_d  = StSlope;
        end
      end
      StSlope: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q[ADDR_WIDTH-1:0];
          wr_data_d = {offset_q, in_data[SLOPE_WIDTH-1:0]};
          count_d   = count_inc;
          if (count_inc == total_q) begin
            state_d    = StFlush;
            in_ready_d = 1'b0;
          end else begin
            state_d = StOffs;
          end
        end
      end
      StFlush: begin
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      total_q    <= '0;
      count_q    <= '0;
      offset_q   <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      count_q    <= count_d;
      offset_q   <= offset_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwl_rom_loader.sv
// Self-checking bench for pwl_rom_loader: cycle table, directed corner loads and
// random full-table loads checked against a beat-counting stream model and RAM image.
module tb_pwl_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  num_entries = '0;
  logic [17:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [35:0] wr_data;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [35:0] ram [256];
  int          wr_count = 0;
  logic [17:0] stream [512];

  typedef struct {
    logic        start;
    logic [8:0]  n;
    logic        valid;
    logic [17:0] data;
    logic        ready;
    logic        wen;
    logic [7:0]  addr;
    logic [35:0] wdata;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [9];

  pwl_rom_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_entries (num_entries),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // RAM image written by the loader, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
      wr_count     <= wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // mode: 0 valid held high, 1 valid toggling, 2 random valid.
  // restart_at: loop cycle at which a stray start is pulsed (-1 none).
  // stop_beats: abandon the load after this many accepted beats (-1 none).
  task automatic run_load(input int n_req, input int mode, input int restart_at,
                          input int stop_beats);
    int   n_eff;
    int   k;
    int   c;
    int   wbase;
    logic acc;
    logic exp_wr;
    n_eff = (n_req > 256) ? 256 : n_req;
    k     = 0;
    c     = 0;
    wbase = wr_count;
    start       = 1'b1;
    num_entries = 9'(n_req);
    in_valid    = 1'b0;
    tick();
    start = 1'b0;
    if (n_eff == 0) begin
      chk("zero_done", 64'(done), 64'(1));
      chk("zero_busy", 64'(busy), 64'(0));
      chk("zero_ready", 64'(in_ready), 64'(0));
      in_valid = 1'b1;
      repeat (3) begin
        tick();
        chk("zero_wr_en", 64'(wr_en), 64'(0));
        chk("zero_done_hold", 64'(done), 64'(1));
      end
      in_valid = 1'b0;
      chk("zero_writes", 64'(wr_count - wbase), 64'(0));
      return;
    end
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_ready", 64'(in_ready), 64'(1));
    chk("start_done", 64'(done), 64'(0));
    while (k < 2 * n_eff && c < 4000 && (stop_beats < 0 || k < stop_beats)) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? stream[k] : 18'($urandom);
      if (c == restart_at) begin
        start       = 1'b1;
        num_entries = 9'd5;
      end
      acc = in_valid && in_ready;
      tick();
      start = 1'b0;
      c++;
      if (acc) k++;
      exp_wr = acc && (k % 2 == 0);
      chk("wr_en", 64'(wr_en), 64'(exp_wr));
      if (exp_wr) begin
        chk("wr_addr", 64'(wr_addr), 64'(k / 2 - 1));
        chk("wr_data", 64'(wr_data), 64'({stream[k-2], stream[k-1]}));
      end
      chk("in_ready", 64'(in_ready), 64'(k < 2 * n_eff));
      chk("busy", 64'(busy), 64'(1));
      chk("done", 64'(done), 64'(0));
    end
    if (stop_beats >= 0) begin
      in_valid = 1'b0;
      return;
    end
    chk("beats", 64'(k), 64'(2 * n_eff));
    in_valid = 1'b1;
    in_data  = 18'h3ffff;
    tick();
    chk("flush_done", 64'(done), 64'(1));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_wr_en", 64'(wr_en), 64'(0));
    chk("flush_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    chk("writes", 64'(wr_count - wbase), 64'(n_eff));
  endtask

  task automatic set_plan_stream();
    stream[0] = 18'h00010; stream[1] = 18'h00001;
    stream[2] = 18'h00020; stream[3] = 18'h00002;
    stream[4] = 18'h00030; stream[5] = 18'h00003;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //            start n      vld   data         rdy   wen   addr  wdata                     busy  done
    tbl[0] = '{1'b1, 9'd3, 1'b1, 18'h00010, 1'b1, 1'b0, 8'd0, 36'h0,                    1'b1, 1'b0};
    tbl[1] = '{1'b0, 9'd0, 1'b1, 18'h00010, 1'b1, 1'b0, 8'd0, 36'h0,                    1'b1, 1'b0};
    tbl[2] = '{1'b0, 9'd0, 1'b1, 18'h00001, 1'b1, 1'b1, 8'd0, {18'h00010, 18'h00001}, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 9'd0, 1'b1, 18'h00020, 1'b1, 1'b0, 8'd0, 36'h0,                    1'b1, 1'b0};
    tbl[4] = '{1'b0, 9'd0, 1'b1, 18'h00002, 1'b1, 1'b1, 8'd1, {18'h00020, 18'h00002}, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 9'd0, 1'b1, 18'h00030, 1'b1, 1'b0, 8'd0, 36'h0,                    1'b1, 1'b0};
    tbl[6] = '{1'b0, 9'd0, 1'b1, 18'h00003, 1'b0, 1'b1, 8'd2, {18'h00030, 18'h00003}, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 9'd0, 1'b1, 18'h00044, 1'b0, 1'b0, 8'd0, 36'h0,                    1'b0, 1'b1};
    tbl[8] = '{1'b0, 9'd0, 1'b0, 18'h00000, 1'b0, 1'b0, 8'd0, 36'h0,                    1'b0, 1'b1};

    do_reset();

    // Plan 1: cycle-exact three-entry load with valid held high.
    for (int i = 0; i < 9; i++) begin
      start       = tbl[i].start;
      num_entries = tbl[i].n;
      in_valid    = tbl[i].valid;
      in_data     = tbl[i].data;
      tick();
      chk($sformatf("t%0d_ready", i), 64'(in_ready), 64'(tbl[i].ready));
      chk($sformatf("t%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].wen));
      if (tbl[i].wen) begin
        chk($sformatf("t%0d_wr_addr", i), 64'(wr_addr), 64'(tbl[i].addr));
        chk($sformatf("t%0d_wr_data", i), 64'(wr_data), 64'(tbl[i].wdata));
      end
      chk($sformatf("t%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("t%0d_done", i), 64'(done), 64'(tbl[i].done));
    end
    start    = 1'b0;
    in_valid = 1'b0;

    // Plan 2: same load with in_valid toggling.
    set_plan_stream();
    run_load(3, 1, -1, -1);

    // Plan 4: stray start during a three-entry load.
    run_load(3, 0, 3, -1);

    // Plan 3: zero-entry load straight from reset.
    do_reset();
    run_load(0, 0, -1, -1);

    // Plan 5: reset after entry 1 is written, then a fresh two-entry load.
    do_reset();
    set_plan_stream();
    run_load(3, 0, -1, 4);
    do_reset();
    tick();
    chk("post_rst_done", 64'(done), 64'(0));
    chk("post_rst_wr_en", 64'(wr_en), 64'(0));
    stream[0] = 18'h1a5a5; stream[1] = 18'h05a5a;
    stream[2] = 18'h2c3c3; stream[3] = 18'h13c3c;
    run_load(2, 0, -1, -1);
    chk("p5_ram0", 64'(ram[0]), 64'({18'h1a5a5, 18'h05a5a}));
    chk("p5_ram1", 64'(ram[1]), 64'({18'h2c3c3, 18'h13c3c}));
    chk("p5_ram2_kept", 64'(ram[2]), 64'({18'h00030, 18'h00003}));

    // Plan 6: full table from a random stream, then an oversized request that clamps.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 512; i++) stream[i] = 18'($urandom);
      run_load((rep == 0) ? 256 : 300, 2, -1, -1);
      for (int i = 0; i < 256; i++) begin
        chk($sformatf("ram%0d_%0d", rep, i), 64'(ram[i]), 64'({stream[2*i], stream[2*i+1]}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
